kernel_buffer_sequencer: RTL and testbench

- Upstream feeder for the kernel buffer distributor. Holds kernel words in D parallel banks, each W bits wide, with 2^ADDR_W rows per bank.
- Words are loaded one at a time over a valid/ready write port.
- On command, it streams whole rows (one word per bank, concatenated) onto ip_bus, which connects directly to the distributor's ip input.
- It also drives the matching controlSignal word {trc, bank}.

---
 rtl/kernel_buffer_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_kernel_buffer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_buffer_sequencer.sv
// kernel_buffer_sequencer
//
// Upstream feeder for the kernel buffer distributor. Kernel words are loaded
// one at a time into D parallel banks of ROWS x W registers. On start, whole
// rows (one word per bank) are streamed onto ip_bus. Each row is offered with
// op_valid/op_ready. The matching controlSignal word {trc, bank} is driven
// alongside each row.
//
// Optional build macro: KBS_TRC_STEP_EN
//    defined   : trc advances by 1 (mod D) after every row handshake
//    undefined : trc holds the value latched at start for the whole stream
//
// Ports
//    CLK, RST           clock (rising edge), synchronous active-high reset
//    clr                IDLE-only pulse, rewinds the write pointer (data kept)
//    wr_valid/wr_ready  write handshake for wr_data (W bits)
//    start              begin streaming (IDLE only); latches num_rows,
//                       trc_cfg and bank_cfg
//    busy, done         busy outside IDLE; done is a one-cycle end pulse
//    op_valid/op_ready  row handshake for ip_bus (W*D bits) / controlSignal
//
// State table
//    state    | meaning
//    S_IDLE   | accepting writes / clr; waiting for start
//    S_STREAM | presenting rows, advancing on each handshake
//    S_FIN    | done pulse for one cycle, then back to IDLE

module kernel_buffer_sequencer #(
   parameter int depth  = 3,
   parameter int D      = 1 << depth,
   parameter int W      = D,
   parameter int ADDR_W = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 clr,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [W-1:0]         wr_data,
   input  logic                 start,
   input  logic [ADDR_W:0]      num_rows,
   input  logic [depth-1:0]     trc_cfg,
   input  logic [depth-1:0]     bank_cfg,
   output logic                 busy,
   output logic                 done,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [W*D-1:0]       ip_bus,
   output logic [2*depth-1:0]   controlSignal
);

   localparam int ROWS  = 1 << ADDR_W;
   localparam int PTR_W = depth + ADDR_W + 1;
   localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(D * ROWS);
   localparam logic [ADDR_W:0]   ROWS_CNT = (ADDR_W+1)'(ROWS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FIN    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]     rd_row_q, rd_row_d;
   logic [ADDR_W:0]     rows_q, rows_d;
   logic [depth-1:0]    trc_q, trc_d;
   logic [depth-1:0]    bank_q, bank_d;
   logic [W*D-1:0]      ip_bus_q, ip_bus_d;
   logic                op_valid_q, op_valid_d;

   logic [W-1:0]        mem_q [D][ROWS];

   logic [ADDR_W:0]     rd_next;
   logic [ADDR_W-1:0]   rd_addr;
   logic [W*D-1:0]      rd_row_data;
   logic [ADDR_W:0]     rows_sat;
   logic                hs;
   logic                wr_fire;

   assign wr_ready = !RST && (state_q == S_IDLE) && !start && !clr
                     && (wr_ptr_q != PTR_FULL);
   assign wr_fire  = wr_valid && wr_ready;

   assign hs       = op_valid_q && op_ready;
   assign rd_next  = rd_row_q + (ADDR_W+1)'(1);
   assign rows_sat = (num_rows > ROWS_CNT) ? ROWS_CNT : num_rows;

   // The address always points at the row that will be loaded at the next
   // edge: row 0 when starting, rd_row+1 while streaming.
   assign rd_addr  = (state_q == S_STREAM) ? rd_next[ADDR_W-1:0] : '0;

   always_comb begin
      rd_row_data = '0;
      for (int j = 0; j < D; j++) begin
         rd_row_data[W*j +: W] = mem_q[j][rd_addr];
      end
   end

   // Memory is deliberately not reset so that contents survive RST.
   always_ff @(posedge CLK) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[depth-1:0]][wr_ptr_q[depth+ADDR_W-1:depth]] <= wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_row_d   = rd_row_q;
      rows_d     = rows_q;
      trc_d      = trc_q;
      bank_d     = bank_q;
      ip_bus_d   = ip_bus_q;
      op_valid_d = op_valid_q;

      case (state_q)
         S_IDLE: begin
            if (clr) begin
               wr_ptr_d = '0;
            end else if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (start) begin
               rows_d   = rows_sat;
               trc_d    = trc_cfg;
               bank_d   = bank_cfg;
               rd_row_d = '0;
               if (rows_sat == '0) begin
                  state_d = S_FIN;
               end else begin
                  state_d    = S_STREAM;
                  ip_bus_d   = rd_row_data;
                  op_valid_d = 1'b1;
               end
            end
         end

         S_STREAM: begin
            if (hs) begin
               rd_row_d = rd_next;
`ifdef KBS_TRC_STEP_EN
               trc_d    = trc_q + depth'(1);
`endif
               if (rd_next < rows_q) begin
                  ip_bus_d = rd_row_data;
               end else begin
                  op_valid_d = 1'b0;
                  state_d    = S_FIN;
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d    = S_IDLE;
            op_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_row_q   <= '0;
         rows_q     <= '0;
         trc_q      <= '0;
         bank_q     <= '0;
         ip_bus_q   <= '0;
         op_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_row_q   <= rd_row_d;
         rows_q     <= rows_d;
         trc_q      <= trc_d;
         bank_q     <= bank_d;
         ip_bus_q   <= ip_bus_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_FIN);
   assign op_valid      = op_valid_q;
   assign ip_bus        = ip_bus_q;
   assign controlSignal = {trc_q, bank_q};

endmodule

// File: tb/tb_kernel_buffer_sequencer.sv
module tb_kernel_buffer_sequencer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        clr = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [7:0]  wr_data = 8'h00;
   logic        start = 1'b0;
   logic [4:0]  num_rows = 5'd0;
   logic [2:0]  trc_cfg = 3'd0;
   logic [2:0]  bank_cfg = 3'd0;
   logic        busy;
   logic        done;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [63:0] ip_bus;
   logic [5:0]  controlSignal;

   kernel_buffer_sequencer #(.depth(3), .D(8), .W(8), .ADDR_W(4)) dut (
      .CLK(CLK), .RST(RST), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .start(start), .num_rows(num_rows), .trc_cfg(trc_cfg), .bank_cfg(bank_cfg),
      .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
      .ip_bus(ip_bus), .controlSignal(controlSignal)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [63:0] data;
      logic [5:0]  ctrl;
   } row_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          rows_seen = 0;
   logic [7:0]  mdl [128];
   int          mptr = 0;
   row_t        exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one expected row per accepted handshake.
   always @(negedge CLK) begin
      if (!RST && op_valid && op_ready) begin
         row_t e;
         rows_seen++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_row: got %h expected none", ip_bus);
         end else begin
            e = exp_q.pop_front();
            chk("row_data", ip_bus, e.data);
            chk("row_ctrl", 64'(controlSignal), 64'(e.ctrl));
         end
      end
   end

   function automatic row_t model_row(input int r, input logic [2:0] trc, input logic [2:0] bank);
      row_t x;
      logic [2:0] t;
      t = trc;
`ifdef KBS_TRC_STEP_EN
      t = trc + 3'(r);
`endif
      x.data = '0;
      for (int j = 0; j < 8; j++) x.data[8*j +: 8] = mdl[r*8 + j];
      x.ctrl = {t, bank};
      return x;
   endfunction

   task automatic write_word(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (wr_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL write_timeout: got wr_ready=0 expected 1");
      end
      @(posedge CLK); #1;
      wr_valid = 1'b0;
      if (ok) begin
         mdl[mptr] = d;
         mptr++;
      end
   endtask

   task automatic stream(input int n, input logic [2:0] trc, input logic [2:0] bank,
                         input logic [3:0] pat, input bit with_wr, input bit push);
      int neff, done_c, got, left, c, base;
      neff = (n > 16) ? 16 : n;
      if (push) for (int r = 0; r < neff; r++) exp_q.push_back(model_row(r, trc, bank));
      left = neff; c = 1;
      while (left > 0) begin
         if (pat[(c-1)%4]) left--;
         c++;
      end
      done_c = c;
      base = rows_seen;
      num_rows = 5'(n); trc_cfg = trc; bank_cfg = bank;
      start = 1'b1;
      if (with_wr) begin wr_valid = 1'b1; wr_data = 8'hEE; end
      @(negedge CLK);
      if (with_wr) chk("wr_ready_with_start", 64'(wr_ready), 64'd0);
      @(posedge CLK); #1;
      start = 1'b0; wr_valid = 1'b0;
      got = 0;
      for (int k = 1; k <= 200; k++) begin
         op_ready = pat[(k-1)%4];
         @(negedge CLK);
         if (done) begin got = k; break; end
         @(posedge CLK); #1;
      end
      chk("done_latency", 64'(got), 64'(done_c));
      @(posedge CLK); #1;
      op_ready = 1'b0;
      @(negedge CLK);
      chk("busy_after", 64'(busy), 64'd0);
      chk("done_width", 64'(done), 64'd0);
      chk("rows_delivered", 64'(rows_seen - base), 64'(neff));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      @(posedge CLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      row_t h;
      // Reset
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("wr_ready_in_reset", 64'(wr_ready), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_op_valid", 64'(op_valid), 64'd0);
      chk("rst_ip_bus", ip_bus, 64'd0);
      chk("rst_ctrl", 64'(controlSignal), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      @(posedge CLK); #1;

      // 16 words, 2 rows, hand-computed expectations
      for (int k = 0; k < 16; k++) write_word(8'(k));
      h.data = 64'h0706050403020100; h.ctrl = 6'b001010; exp_q.push_back(h);
      h.data = 64'h0F0E0D0C0B0A0908; h.ctrl = 6'b001010;
`ifdef KBS_TRC_STEP_EN
      h.ctrl = 6'b010010;
`endif
      exp_q.push_back(h);
      stream(2, 3'd1, 3'd2, 4'b1111, 1'b0, 1'b0);

      // Fill all 128 words, then confirm the full stall
      clr = 1'b1; @(posedge CLK); #1; clr = 1'b0; mptr = 0;
      for (int k = 0; k < 128; k++) write_word(8'((k*3 + 1) & 8'hFF));
      wr_valid = 1'b1; wr_data = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("wr_ready_full", 64'(wr_ready), 64'd0);
         @(posedge CLK); #1;
      end
      wr_valid = 1'b0;

      // Saturated row count: 20 requested, 16 delivered
      stream(20, 3'd3, 3'd5, 4'b1111, 1'b0, 1'b1);

      // clr reopens the write port; next word lands in bank0 row0
      clr = 1'b1; @(posedge CLK); #1; clr = 1'b0; mptr = 0;
      @(negedge CLK);
      chk("wr_ready_after_clr", 64'(wr_ready), 64'd1);
      @(posedge CLK); #1;
      write_word(8'hAA);
      stream(1, 3'd0, 3'd0, 4'b1111, 1'b0, 1'b1);

      // Back-pressure pattern 1,0,0,1
      stream(3, 3'd5, 3'd1, 4'b1001, 1'b0, 1'b1);

      // Zero rows
      stream(0, 3'd2, 3'd2, 4'b1111, 1'b0, 1'b1);

      // start and wr_valid together: write rejected, pointer unchanged
      stream(1, 3'd0, 3'd7, 4'b1111, 1'b1, 1'b1);
      write_word(8'h55);
      stream(1, 3'd4, 3'd6, 4'b1111, 1'b0, 1'b1);

      // RST during the 2nd row
      exp_q.push_back(model_row(0, 3'd1, 3'd1));
      num_rows = 5'd4; trc_cfg = 3'd1; bank_cfg = 3'd1;
      start = 1'b1; @(posedge CLK); #1; start = 1'b0;
      op_ready = 1'b1; @(posedge CLK); #1;
      RST = 1'b1; op_ready = 1'b0; @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_mid_op_valid", 64'(op_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_ip_bus", ip_bus, 64'd0);
      chk("rst_mid_queue", 64'(exp_q.size()), 64'd0);
      chk("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
      @(posedge CLK); #1;
      mptr = 0;
      stream(4, 3'd2, 3'd3, 4'b1111, 1'b0, 1'b1);

      // trc sequence 6,7,0,1 when stepping is enabled (constant 6 otherwise)
      stream(4, 3'd6, 3'd4, 4'b1111, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
